step_judge: RTL and testbench

- Judges each player's debounced button presses against the current target step of a two-player 4-arrow dance game.
- Sits directly downstream of the button debouncer (a_btn/b_btn are its debounced, synchronised outputs) and upstream of display/score logic.
- Takes steps from a pattern source via a valid/ready handshake and times each step slot.
- Emits per-player result pulses and running scores.

---
 rtl/dance_pkg.sv | 13 +
 rtl/player_judge.sv | 122 ++++++++++++
 rtl/step_judge.sv | 127 ++++++++++++
 tb/tb_step_judge.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dance_pkg.sv
// Shared result codes, FSM state encoding and combo threshold for the dance step judge.
package dance_pkg;

  localparam logic [1:0] RES_MISS    = 2'b00;
  localparam logic [1:0] RES_GOOD    = 2'b01;
  localparam logic [1:0] RES_PERFECT = 2'b10;
  localparam logic [1:0] RES_WRONG   = 2'b11;

  typedef enum logic [1:0] {IDLE, FETCH, ACTIVE, DONE} state_e;

  localparam int unsigned COMBO_TH = 4;

endpackage

// File: rtl/player_judge.sv
// Per-player judging: button edge detect, judged flag, result pulse and saturating score.
// Defining COMBO_EN adds a combo counter that doubles points once the streak reaches COMBO_TH.
module player_judge
  import dance_pkg::*;
#(
  parameter int unsigned SCORE_W = 10
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               active_i,
  input  logic               slot_start_i,
  input  logic               slot_end_i,
  input  logic               perfect_i,
  input  logic [3:0]         target_i,
  input  logic [3:0]         btn_i,
  output logic               res_valid_o,
  output logic [1:0]         res_o,
  output logic [SCORE_W-1:0] score_o
`ifdef COMBO_EN
  ,
  output logic [7:0]         combo_o
`endif
);

  // Wide enough to hold score plus the largest (doubled) award without wrapping.
  localparam int unsigned SumW = ((SCORE_W > 3) ? SCORE_W : 3) + 1;

  logic [3:0]         prev_q;
  logic [3:0]         rise;
  logic               judged_q, judged_d;
  logic               res_valid_q;
  logic [1:0]         res_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               ev_valid;
  logic [1:0]         ev_code;
  logic [2:0]         pts;
  logic [SumW-1:0]    sum;
`ifdef COMBO_EN
  logic [7:0]         combo_q, combo_d;
`endif

  always_comb begin
    rise     = btn_i & ~prev_q;
    ev_valid = 1'b0;
    ev_code  = RES_MISS;
    if (active_i && !judged_q) begin
      if (|(rise & ~target_i)) begin
        ev_valid = 1'b1;
        ev_code  = RES_WRONG;
      end else if ((|rise) && (btn_i == target_i)) begin
        ev_valid = 1'b1;
        ev_code  = perfect_i ? RES_PERFECT : RES_GOOD;
      end else if (slot_end_i && (|target_i)) begin
        ev_valid = 1'b1;
        ev_code  = RES_MISS;
      end
    end
  end

  always_comb begin
    pts = 3'd0;
    if (ev_valid && (ev_code == RES_PERFECT)) begin
      pts = 3'd2;
    end else if (ev_valid && (ev_code == RES_GOOD)) begin
      pts = 3'd1;
    end
`ifdef COMBO_EN
    combo_d = combo_q;
    if (ev_valid) begin
      if (pts != 3'd0) begin
        // Streak length before this hit decides the bonus.
        if (combo_q >= 8'(COMBO_TH)) pts = pts << 1;
        if (combo_q != 8'hFF) combo_d = combo_q + 8'd1;
      end else begin
        combo_d = '0;
      end
    end
    if (clear_i) combo_d = '0;
`endif
    sum     = SumW'(score_q) + SumW'(pts);
    score_d = (|sum[SumW-1:SCORE_W]) ? '1 : sum[SCORE_W-1:0];
    if (clear_i) score_d = '0;

    judged_d = judged_q;
    if (slot_start_i) begin
      judged_d = 1'b0;
    end else if (ev_valid) begin
      judged_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q      <= '0;
      judged_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= RES_MISS;
      score_q     <= '0;
`ifdef COMBO_EN
      combo_q     <= '0;
`endif
    end else begin
      prev_q      <= btn_i;
      judged_q    <= judged_d;
      res_valid_q <= ev_valid;
      if (ev_valid) res_q <= ev_code;
      score_q     <= score_d;
`ifdef COMBO_EN
      combo_q     <= combo_d;
`endif
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_o       = res_q;
  assign score_o     = score_q;
`ifdef COMBO_EN
  assign combo_o     = combo_q;
`endif

endmodule

// File: rtl/step_judge.sv
// Two-player step judge: game FSM, step-slot timer and step handshake; judging per player.
// Optional COMBO_EN macro adds a_combo/b_combo ports and streak-doubled scoring.
module step_judge
  import dance_pkg::*;
#(
  parameter int unsigned BEAT_CYCLES    = 25_000_000,
  parameter int unsigned PERFECT_CYCLES = 5_000_000,
  parameter int unsigned SCORE_W        = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         a_btn,
  input  logic [3:0]         b_btn,
  input  logic [3:0]         step_target,
  input  logic               step_last,
  input  logic               step_valid,
  output logic               step_ready,
  output logic [3:0]         target_out,
  output logic               busy,
  output logic               done,
  output logic               a_res_valid,
  output logic               b_res_valid,
  output logic [1:0]         a_res,
  output logic [1:0]         b_res,
  output logic [SCORE_W-1:0] a_score,
  output logic [SCORE_W-1:0] b_score
`ifdef COMBO_EN
  ,
  output logic [7:0]         a_combo,
  output logic [7:0]         b_combo
`endif
);

  localparam int unsigned CntW = $clog2(BEAT_CYCLES);

  state_e          state_q;
  logic [CntW-1:0] slot_cnt_q;
  logic [3:0]      target_q;
  logic            last_q;

  logic handshake, slot_end, perfect, active, clear;

  assign handshake = (state_q == FETCH) && step_valid;
  assign active    = (state_q == ACTIVE);
  assign slot_end  = active && (slot_cnt_q == CntW'(BEAT_CYCLES - 1));
  assign perfect   = 32'(slot_cnt_q) < PERFECT_CYCLES;
  assign clear     = start && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      slot_cnt_q <= '0;
      target_q   <= '0;
      last_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) state_q <= FETCH;
        end
        FETCH: begin
          if (step_valid) begin
            target_q   <= step_target;
            last_q     <= step_last;
            slot_cnt_q <= '0;
            state_q    <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (slot_cnt_q == CntW'(BEAT_CYCLES - 1)) begin
            state_q <= last_q ? DONE : FETCH;
          end else begin
            slot_cnt_q <= slot_cnt_q + CntW'(1);
          end
        end
      endcase
    end
  end

  assign step_ready = handshake;
  assign target_out = target_q;
  assign busy       = (state_q == FETCH) || (state_q == ACTIVE);
  assign done       = (state_q == DONE);

  player_judge #(
    .SCORE_W(SCORE_W)
  ) u_player_a (
    .clk_i       (clock),
    .reset_i     (reset),
    .clear_i     (clear),
    .active_i    (active),
    .slot_start_i(handshake),
    .slot_end_i  (slot_end),
    .perfect_i   (perfect),
    .target_i    (target_q),
    .btn_i       (a_btn),
    .res_valid_o (a_res_valid),
    .res_o       (a_res),
    .score_o     (a_score)
`ifdef COMBO_EN
    ,
    .combo_o     (a_combo)
`endif
  );

  player_judge #(
    .SCORE_W(SCORE_W)
  ) u_player_b (
    .clk_i       (clock),
    .reset_i     (reset),
    .clear_i     (clear),
    .active_i    (active),
    .slot_start_i(handshake),
    .slot_end_i  (slot_end),
    .perfect_i   (perfect),
    .target_i    (target_q),
    .btn_i       (b_btn),
    .res_valid_o (b_res_valid),
    .res_o       (b_res),
    .score_o     (b_score)
`ifdef COMBO_EN
    ,
    .combo_o     (b_combo)
`endif
  );

endmodule

// File: tb/tb_step_judge.sv
// Bench for step_judge: per-slot vector table plus directed reset, stall, saturation sequences.
module tb_step_judge;

  localparam int unsigned BEAT = 20;
  localparam int unsigned PERF = 5;
  localparam int unsigned SW   = 4;
  localparam int NV = -1;
  localparam logic [1:0] RM = 2'b00, RG = 2'b01, RP = 2'b10, RW = 2'b11;

  logic          clock, reset, start, step_last, step_valid, step_ready, busy, done;
  logic [3:0]    a_btn, b_btn, step_target, target_out;
  logic          a_res_valid, b_res_valid;
  logic [1:0]    a_res, b_res;
  logic [SW-1:0] a_score, b_score;
`ifdef COMBO_EN
  logic [7:0]    a_combo, b_combo;
`endif

  int checks = 0;
  int errors = 0;

  step_judge #(
    .BEAT_CYCLES   (BEAT),
    .PERFECT_CYCLES(PERF),
    .SCORE_W       (SW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .a_btn      (a_btn),
    .b_btn      (b_btn),
    .step_target(step_target),
    .step_last  (step_last),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .target_out (target_out),
    .busy       (busy),
    .done       (done),
    .a_res_valid(a_res_valid),
    .b_res_valid(b_res_valid),
    .a_res      (a_res),
    .b_res      (b_res),
    .a_score    (a_score),
    .b_score    (b_score)
`ifdef COMBO_EN
    ,
    .a_combo    (a_combo),
    .b_combo    (b_combo)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One slot: step fields, button events (level, slot_cnt), expected pulse index/code/score.
  // Pulse index i is the slot_cnt seen after the edge; 20 is the cycle after the slot.
  typedef struct {
    logic [3:0] tgt;
    logic       last;
    logic       rel;
    logic [3:0] a1;  int ac1;
    logic [3:0] a2;  int ac2;
    logic [3:0] b1;  int bc1;
    logic [3:0] b2;  int bc2;
    int a_at; logic [1:0] a_code; int a_sc; int a_cb;
    int b_at; logic [1:0] b_code; int b_sc;
  } vec_t;

  vec_t main_v[8];
  vec_t sat_v[9];
  int   sat_sc[8];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic run_slot(input vec_t v, input string tag);
    int na, nb, aat, bat;
    logic [1:0] acode, bcode;
    na = 0; nb = 0; aat = NV; bat = NV; acode = RM; bcode = RM;
    step_target = v.tgt;
    step_last   = v.last;
    step_valid  = 1'b1;
    #1;
    chk($sformatf("%s ready", tag), int'(step_ready), 1);
    tick;
    step_valid = 1'b0;
    chk($sformatf("%s target_out", tag), int'(target_out), int'(v.tgt));
    chk($sformatf("%s busy", tag), int'(busy), 1);
    for (int i = 0; i <= 20; i++) begin
      if (a_res_valid) begin na++; aat = i; acode = a_res; end
      if (b_res_valid) begin nb++; bat = i; bcode = b_res; end
      if (i < 20) begin
        if (i == v.ac1) a_btn = v.a1;
        if (i == v.ac2) a_btn = v.a2;
        if (i == v.bc1) b_btn = v.b1;
        if (i == v.bc2) b_btn = v.b2;
        tick;
      end
    end
    chk($sformatf("%s a pulses", tag), na, (v.a_at == NV) ? 0 : 1);
    chk($sformatf("%s b pulses", tag), nb, (v.b_at == NV) ? 0 : 1);
    if (v.a_at != NV) begin
      chk($sformatf("%s a at", tag), aat, v.a_at);
      chk($sformatf("%s a code", tag), int'(acode), int'(v.a_code));
    end
    if (v.b_at != NV) begin
      chk($sformatf("%s b at", tag), bat, v.b_at);
      chk($sformatf("%s b code", tag), int'(bcode), int'(v.b_code));
    end
    chk($sformatf("%s a score", tag), int'(a_score), v.a_sc);
    chk($sformatf("%s b score", tag), int'(b_score), v.b_sc);
`ifdef COMBO_EN
    chk($sformatf("%s a combo", tag), int'(a_combo), v.a_cb);
`endif
    if (v.rel) begin
      a_btn = '0;
      b_btn = '0;
    end
  endtask

  initial begin
    int npulse, nbad;
    reset = 1'b1; start = 1'b0; a_btn = '0; b_btn = '0;
    step_target = '0; step_last = 1'b0; step_valid = 1'b0;

    main_v[0] = '{4'b0001, 0, 1, 4'b0001, 2, 4'b0000, NV, 4'b0000, NV, 4'b0000, NV,
                  3, RP, 2, 1, 20, RM, 0};
    main_v[1] = '{4'b0101, 0, 1, 4'b0001, 3, 4'b0101, 8, 4'b0101, 4, 4'b0000, NV,
                  9, RG, 3, 2, 5, RP, 2};
    main_v[2] = '{4'b0101, 0, 1, 4'b0001, 1, 4'b0011, 2, 4'b0100, 4, 4'b0000, NV,
                  3, RW, 3, 0, 20, RM, 2};
    main_v[3] = '{4'b0010, 0, 0, 4'b0010, 19, 4'b0000, NV, 4'b1000, 0, 4'b0000, NV,
                  20, RG, 4, 1, 1, RW, 2};
    main_v[4] = '{4'b0010, 0, 1, 4'b0000, NV, 4'b0000, NV, 4'b0000, NV, 4'b0000, NV,
                  20, RM, 4, 0, 20, RM, 2};
    main_v[5] = '{4'b0000, 0, 1, 4'b0100, 6, 4'b0000, NV, 4'b0000, NV, 4'b0000, NV,
                  7, RW, 4, 0, NV, RM, 2};
    main_v[6] = '{4'b1111, 0, 1, 4'b1111, 4, 4'b0000, NV, 4'b1111, 5, 4'b0000, NV,
                  5, RP, 6, 1, 6, RG, 3};
    main_v[7] = '{4'b1000, 1, 1, 4'b1000, 0, 4'b0000, NV, 4'b0100, 10, 4'b1100, 11,
                  1, RP, 8, 2, 11, RW, 3};
`ifdef COMBO_EN
    sat_sc = '{2, 4, 6, 8, 12, 15, 15, 15};
`else
    sat_sc = '{2, 4, 6, 8, 10, 12, 14, 15};
`endif
    for (int k = 0; k < 8; k++) begin
      sat_v[k] = '{4'b0001, 0, 1, 4'b0001, 0, 4'b0000, NV, 4'b0000, NV, 4'b0000, NV,
                   1, RP, sat_sc[k], k + 1, 20, RM, 0};
    end
    sat_v[8] = '{4'b0001, 0, 1, 4'b0000, NV, 4'b0000, NV, 4'b0000, NV, 4'b0000, NV,
                 20, RM, 15, 0, 20, RM, 0};

    tick; tick;
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst ready", int'(step_ready), 0);
    chk("rst target", int'(target_out), 0);
    chk("rst a_valid", int'(a_res_valid), 0);
    chk("rst a_score", int'(a_score), 0);
    chk("rst b_score", int'(b_score), 0);
    reset = 1'b0;
    tick;
    chk("idle busy", int'(busy), 0);

    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start busy", int'(busy), 1);
    chk("fetch ready low", int'(step_ready), 0);

    for (int r = 0; r < 8; r++) run_slot(main_v[r], $sformatf("main%0d", r));
    chk("last done", int'(done), 1);
    chk("last busy", int'(busy), 0);
    tick;
    chk("done holds", int'(done), 1);

    start = 1'b1;
    tick;
    start = 1'b0;
    chk("restart a_score", int'(a_score), 0);
    chk("restart b_score", int'(b_score), 0);
    chk("restart busy", int'(busy), 1);
    chk("restart done", int'(done), 0);

    // Stall in FETCH with button activity and an ignored start.
    npulse = 0; nbad = 0;
    for (int k = 0; k < 50; k++) begin
      a_btn = ((k % 6) < 3) ? 4'b0001 : 4'b0000;
      b_btn = ((k % 4) < 2) ? 4'b1010 : 4'b0000;
      start = (k == 10);
      tick;
      if (a_res_valid || b_res_valid) npulse++;
      if (!busy || done || step_ready) nbad++;
    end
    start = 1'b0; a_btn = '0; b_btn = '0;
    chk("stall pulses", npulse, 0);
    chk("stall state", nbad, 0);

    for (int r = 0; r < 9; r++) run_slot(sat_v[r], $sformatf("sat%0d", r));

    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start in fetch a_score", int'(a_score), 15);
    chk("start in fetch busy", int'(busy), 1);

    // Reset lands together with a judged edge; no pulse must survive.
    step_target = 4'b0001; step_valid = 1'b1;
    tick;
    step_valid = 1'b0;
    tick; tick;
    a_btn = 4'b0001;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid rst a_valid", int'(a_res_valid), 0);
    chk("mid rst a_res", int'(a_res), 0);
    chk("mid rst a_score", int'(a_score), 0);
    chk("mid rst busy", int'(busy), 0);
    chk("mid rst target", int'(target_out), 0);
    tick;
    chk("post rst a_valid", int'(a_res_valid), 0);
    chk("post rst busy", int'(busy), 0);
    a_btn = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
